// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-write FIFO between the core data port and memory,
// with load RAW hazard detection (stall) and optional store-to-load forwarding.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   MemWrite, MemRead   core store / load request this cycle
//   DataAdr             byte address of the store or load
//   WriteData           lane-aligned store data
//   byteEnable          store byte lanes
//   stall               core must hold PC and retry
//   fwd_hit, fwd_data   load satisfied from the buffer
//   mem_valid           head entry presented to memory
//   mem_addr/wdata/be   head entry contents
//   mem_ready           memory accepts head this cycle
//   count, full, empty  occupancy status (registered)
//
// Build option: define STORE_FWD_EN to forward full-word buffered stores to
// loads instead of stalling.

module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic                   MemRead,
  input  logic [AW-1:0]          DataAdr,
  input  logic [DW-1:0]          WriteData,
  input  logic [DW/8-1:0]        byteEnable,
  output logic                   stall,
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data,
  output logic                   mem_valid,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  output logic [DW/8-1:0]        mem_be,
  input  logic                   mem_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int BW = DW / 8;

  logic [AW-1:0] addrQ [DEPTH];
  logic [DW-1:0] dataQ [DEPTH];
  logic [BW-1:0] beQ   [DEPTH];

  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [DEPTH-1:0] matchVec;
  logic             hazard;
  logic             fullStall;
  logic             hazStall;
  logic             push;
  logic             pop;

  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;

  assign mem_valid = !empty;
  assign mem_addr  = addrQ[rdPtr];
  assign mem_wdata = dataQ[rdPtr];
  assign mem_be    = beQ[rdPtr];

  // matchVec is indexed by age: bit 0 is the head, higher bits are younger.
  // Only occupied slots (age < count) take part in the compare.
  always_comb begin
    matchVec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < count &&
          addrQ[rdPtr + PW'(k)][AW-1:2] == DataAdr[AW-1:2]) begin
        matchVec[k] = 1'b1;
      end
    end
  end

  assign hazard = MemRead && (matchVec != '0);

`ifdef STORE_FWD_EN
  logic [PW-1:0] hitIdx;

  // Youngest matching entry wins: later ages overwrite earlier ones.
  always_comb begin
    hitIdx = rdPtr;
    for (int k = 0; k < DEPTH; k++) begin
      if (matchVec[k]) begin
        hitIdx = rdPtr + PW'(k);
      end
    end
  end

  // Only a full-word store can satisfy the load; partial ones still stall.
  always_comb begin
    fwd_hit  = hazard && (beQ[hitIdx] == '1);
    fwd_data = '0;
    if (fwd_hit) begin
      fwd_data = dataQ[hitIdx];
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  assign fullStall = MemWrite && full;
  assign hazStall  = hazard && !fwd_hit;
  assign stall     = fullStall || hazStall;

  // A full buffer refuses the store even if the head drains this cycle.
  assign push = MemWrite && !full && !hazStall;
  assign pop  = mem_valid && mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      unique case (1'b1)
        (push && !pop): count <= count + 1'b1;
        (pop && !push): count <= count - 1'b1;
        default:        count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addrQ[wrPtr] <= DataAdr;
      dataQ[wrPtr] <= WriteData;
      beQ[wrPtr]   <= byteEnable;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed + random checks of store_write_buffer
// against a queue-based reference model.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          MemWrite;
  logic          MemRead;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic [BW-1:0] byteEnable;
  logic          stall;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready;
  logic [$clog2(DEPTH):0] count;
  logic          full;
  logic          empty;

  store_write_buffer #(
    .DEPTH(DEPTH),
    .AW(AW),
    .DW(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .byteEnable(byteEnable),
    .stall(stall),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_ready(mem_ready),
    .count(count),
    .full(full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] memLog[$];
  int            nVec = 0;
  int            nErr = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] b, input logic rdy);
    MemWrite   = w;
    MemRead    = r;
    DataAdr    = a;
    WriteData  = d;
    byteEnable = b;
    mem_ready  = rdy;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit            haz;
    bit            eFwd;
    bit            eStall;
    bit            doPop;
    bit            doPush;
    int            yi;
    logic [DW-1:0] eData;
    ent_t          e;
    @(negedge clk);
    haz = 0;
    yi  = 0;
    foreach (q[i]) begin
      if (MemRead && q[i].a[AW-1:2] == DataAdr[AW-1:2]) begin
        haz = 1;
        yi  = i;
      end
    end
    eFwd   = FWD && haz && (q[yi].b == 4'hF);
    eData  = eFwd ? q[yi].d : '0;
    eStall = (MemWrite && q.size() == DEPTH) || (haz && !eFwd);
    check("count", 64'(count), 64'(q.size()));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
    check("stall", 64'(stall), 64'(eStall));
    check("fwd_hit", 64'(fwd_hit), 64'(eFwd));
    check("fwd_data", 64'(fwd_data), 64'(eData));
    if (q.size() != 0) begin
      check("mem_addr", 64'(mem_addr), 64'(q[0].a));
      check("mem_wdata", 64'(mem_wdata), 64'(q[0].d));
      check("mem_be", 64'(mem_be), 64'(q[0].b));
    end
    if (mem_valid && mem_ready) memLog.push_back(mem_addr);
    doPop  = (q.size() != 0) && mem_ready;
    doPush = MemWrite && (q.size() < DEPTH) && !eStall;
    e.a = DataAdr;
    e.d = WriteData;
    e.b = byteEnable;
    @(posedge clk);
    if (doPop) void'(q.pop_front());
    if (doPush) q.push_back(e);
    #1;
  endtask

  task automatic doReset();
    drive(0, 0, '0, '0, '0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    check("rst_count", 64'(count), 0);
    check("rst_empty", 64'(empty), 1);
    check("rst_full", 64'(full), 0);
    check("rst_valid", 64'(mem_valid), 0);
    check("rst_stall", 64'(stall), 0);
    check("rst_fwd", 64'(fwd_hit), 0);
    check("rst_fdata", 64'(fwd_data), 0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, '0, '0, '0, 0);
    doReset();

    // three posted stores held by memory
    drive(1, 0, 100, 32'h11, 4'hF, 0); cycle();
    drive(1, 0, 104, 32'h22, 4'hF, 0); cycle();
    drive(1, 0, 108, 32'h33, 4'hF, 0); cycle();
    drive(0, 0, 0, 0, 0, 0);
    check("tp1_count", 64'(count), 3);
    check("tp1_addr", 64'(mem_addr), 100);
    check("tp1_stall", 64'(stall), 0);
    cycle();

    // fill, refused fifth store, then accepted after one pop
    doReset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 32'(200 + 4 * k), 32'(k), 4'hF, 0);
      cycle();
    end
    drive(1, 0, 216, 32'h5, 4'hF, 0);
    #1;
    check("tp2_full", 64'(full), 1);
    check("tp2_stall", 64'(stall), 1);
    cycle();
    drive(1, 0, 216, 32'h5, 4'hF, 1); cycle();
    drive(1, 0, 216, 32'h5, 4'hF, 0); cycle();
    drive(0, 0, 0, 0, 0, 0);
    check("tp2_count", 64'(count), 4);
    check("tp2_head", 64'(mem_addr), 204);
    cycle();

    // load hazard on a full-word store
    doReset();
    drive(1, 0, 100, 25, 4'hF, 0); cycle();
    drive(1, 0, 104, 4096, 4'hF, 0); cycle();
    drive(0, 1, 104, 0, 0, 0);
    #1;
    check("tp3_stall", 64'(stall), FWD ? 0 : 1);
    check("tp3_fwd", 64'(fwd_hit), FWD ? 1 : 0);
    check("tp3_fdata", 64'(fwd_data), FWD ? 4096 : 0);
    cycle(); cycle();
    drive(0, 1, 104, 0, 0, 1);
    for (int k = 0; k < 4; k++) cycle();
    check("tp3_drained", 64'(stall), 0);

    // partial store always stalls the load
    doReset();
    drive(1, 0, 105, 32'h0000AA00, 4'b0010, 0); cycle();
    drive(0, 1, 104, 0, 0, 0);
    #1;
    check("tp4_stall", 64'(stall), 1);
    check("tp4_fwd", 64'(fwd_hit), 0);
    cycle();
    drive(0, 1, 104, 0, 0, 1); cycle();
    check("tp4_clear", 64'(stall), 0);

    // steady push+pop across pointer wrap
    doReset();
    memLog.delete();
    drive(1, 0, 96, 32'h60, 4'hF, 0); cycle();
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 32'(100 + 4 * k), 32'(k), 4'hF, 1);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("tp5_n", 64'(memLog.size()), 10);
    foreach (memLog[i]) check("tp5_order", 64'(memLog[i]), 64'(96 + 4 * i));

    // asynchronous reset while draining with a stalled load
    doReset();
    drive(1, 0, 100, 1, 4'hF, 0); cycle();
    drive(1, 0, 104, 2, 4'b0011, 0); cycle();
    drive(1, 0, 108, 3, 4'hF, 0); cycle();
    drive(0, 1, 104, 0, 0, 1);
    #1;
    check("tp6_pre", 64'(stall), 1);
    #1;
    reset = 1'b1;
    #1;
    check("tp6_valid", 64'(mem_valid), 0);
    check("tp6_count", 64'(count), 0);
    check("tp6_full", 64'(full), 0);
    check("tp6_stall", 64'(stall), 0);
    check("tp6_fwd", 64'(fwd_hit), 0);
    q.delete();
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int            op;
      logic [BW-1:0] b;
      op = $urandom_range(0, 3);
      b  = ($urandom_range(0, 1) == 1) ? 4'hF : BW'($urandom);
      drive(op == 0, op == 1, AW'($urandom_range(0, 63)),
            DW'($urandom), b, $urandom_range(0, 9) < 4);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

- Posted-write FIFO between the single-cycle core's data-memory port and the data memory.
- Captures each store (address, data, byte enables) in the cycle `MemWrite` is asserted, then drains entries in order to memory over a valid/ready handshake. Stores therefore never wait on memory latency.
- Protects loads from reading stale memory by detecting read-after-write hazards against buffered entries. It either stalls the core or, when configured, forwards data.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `AW`, 32, address width.
- `DW`, 32, data width; `DW/8` byte enables.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `MemWrite` in 1: core store request this cycle.
- `MemRead` in 1: core load request this cycle.
- `DataAdr` in AW: core byte address (store or load).
- `WriteData` in DW: store data, already lane-aligned.
- `byteEnable` in DW/8: store byte lanes.
- `stall` out 1: core must hold PC and retry the instruction.
- `fwd_hit` out 1: load is satisfied from the buffer (only with `STORE_FWD_EN`).
- `fwd_data` out DW: forwarded load word.
- `mem_valid` out 1: head entry presented to memory.
- `mem_addr` out AW, `mem_wdata` out DW, `mem_be` out DW/8: head entry contents.
- `mem_ready` in 1: memory accepts head this cycle.
- `count` out $clog2(DEPTH)+1: occupied entries.
- `full` out 1, `empty` out 1.

## Operation
- Storage: circular array with write pointer, read pointer and occupancy counter.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` ranges 0..DEPTH.
- Push: `MemWrite & !full & !stall_hazard` writes {`DataAdr`, `WriteData`, `byteEnable`} at the write pointer, then the write pointer increments.
- Pop: `mem_valid & mem_ready` increments the read pointer.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Push while full is refused (`stall`=1) even if a pop occurs the same cycle. The core retries the next cycle.
- `mem_valid` = `!empty`. `mem_addr`/`mem_wdata`/`mem_be` are driven from the head entry and are stable while `mem_valid & !mem_ready`.
- Hazard match: `MemRead` and `DataAdr[AW-1:2]` equals any occupied entry's `addr[AW-1:2]`.
- Without forwarding: a hazard sets `stall`=1 until no occupied entry matches, i.e. until the matching entries drain.
- `stall` = `(MemWrite & full) | (MemRead & hazard & !fwd_hit)`.
- `MemWrite` and `MemRead` asserted together is illegal; the bench never drives it.
- Entry ordering to memory equals program store order, with no coalescing.

## Timing
- Reset (asynchronous, immediate): pointers 0, `count` 0, `empty` 1, `full` 0, `mem_valid` 0, `stall` 0, `fwd_hit` 0, `fwd_data` 0.
- Reset mid-drain discards all entries; `mem_valid` drops without waiting for `mem_ready`.
- Push-to-memory latency: an entry pushed at edge N shows `mem_valid`=1 after edge N. There is no same-cycle bypass to memory.
- Throughput: one push and one pop per cycle.
- `stall`, `fwd_hit` and `fwd_data` are combinational from the inputs and current state, and settle within the same cycle.
- `full`, `empty` and `count` change only on clock edges.

## Configuration
- `STORE_FWD_EN` defined:
  - On a hazard, the youngest matching entry is selected.
  - If its `be` is all ones, `fwd_hit`=1, `fwd_data` equals its data, and `stall`=0.
  - Otherwise (partial store) `stall`=1 as in the non-forwarding case.
- `STORE_FWD_EN` undefined: `fwd_hit` and `fwd_data` are tied to 0, and every hazard stalls.

## Test plan
- Reset, then push stores to 100, 104, 108 with `mem_ready`=0 -> `count`=3; `mem_addr`=100 held; `stall`=0.
- Push 4 stores with `mem_ready`=0, then a 5th -> `full`=1 and `stall`=1. Raise `mem_ready` for one cycle -> the 5th is accepted on the next edge and `count` stays 4.
- Load from 104 while entries {100:25, 104:4096} are buffered:
  - Without the macro: `stall`=1 until 104 drains, then 0.
  - With the macro: `fwd_hit`=1, `fwd_data`=4096, `stall`=0.
- Store 0xAA to byte 105 (`be`=0010), then load 104 -> `stall`=1 in both configurations until the entry drains.
- Continuous push and pop for 10 cycles across pointer wrap -> memory sees addresses 96..132 in order; `count` stays constant.
- Assert `reset` mid-drain with `count`=3 -> `mem_valid`, `count`, `full`, `stall` and `fwd_hit` go to 0 immediately, before the next clock edge.
